// File: rtl/board_pkg.sv
// Shared board-input definitions: debounce FSM states and default timing constants at 100 MHz.
package board_pkg;

    typedef enum logic {
        STABLE   = 1'b0,
        CHANGING = 1'b1
    } db_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int REPEAT_CYCLES_DEF   = 25_000_000;

endpackage

// File: rtl/debounce_cell.sv
// One push-button: 2-flop synchronizer, STABLE/CHANGING debounce FSM and debounced level.
// `toggle` is high in the cycle before db changes, letting the parent register edge pulses aligned with db.
module debounce_cell
    import board_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk0,
    input  logic rst0,
    input  logic raw,
    output logic db,
    output logic toggle
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    db_state_t        state;
    db_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             db_nxt;

    // synchronizer stages
    always_ff @(posedge clk0 or negedge rst0) begin
        if (!rst0) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    always_ff @(posedge clk0 or negedge rst0) begin
        if (!rst0) begin
            state <= STABLE;
            cnt   <= '0;
            db    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            db    <= db_nxt;
        end
    end

    // db flips on the cycle the count would reach DEBOUNCE_CYCLES; cnt never exceeds it
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        db_nxt    = db;
        toggle    = 1'b0;
        unique case (state)
            STABLE: begin
                cnt_nxt = '0;
                if (sync_p1 != db) begin
                    if (CNT_LAST == '0) begin
                        toggle = 1'b1;
                    end else begin
                        state_nxt = CHANGING;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            CHANGING: begin
                if (sync_p1 == db) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else if (cnt >= CNT_LAST) begin
                    toggle    = 1'b1;
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
        endcase
        if (toggle) begin
            db_nxt = ~db;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Board input conditioning: debounced reset request (btnL), step pulse (btnR), synchronized switches.
// Optional auto-repeat of the step pulse while btnR is held: define BTN_CONDITIONER_AUTOREPEAT_EN.
module btn_conditioner
    import board_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SW_WIDTH        = 16,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic                clk0,
    input  logic                rst0,
    input  logic                btn_l_raw,
    input  logic                btn_r_raw,
    input  logic [SW_WIDTH-1:0] sw_raw,
    output logic                rst_req,
    output logic                en_pulse,
    output logic [SW_WIDTH-1:0] sw_sync,
    output logic                btn_r_level
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("REPEAT_CYCLES must be at least 1");
    end

    logic                btn_l_toggle_unused;
    logic                r_db;
    logic                r_toggle;
    logic [SW_WIDTH-1:0] sw_p0;

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
        .clk0   (clk0),
        .rst0   (rst0),
        .raw    (btn_l_raw),
        .db     (rst_req),
        .toggle (btn_l_toggle_unused)
    );

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
        .clk0   (clk0),
        .rst0   (rst0),
        .raw    (btn_r_raw),
        .db     (r_db),
        .toggle (r_toggle)
    );

    assign btn_r_level = r_db;

    // switch synchronizer stages
    always_ff @(posedge clk0 or negedge rst0) begin
        if (!rst0) begin
            sw_p0   <= '0;
            sw_sync <= '0;
        end else begin
            sw_p0   <= sw_raw;
            sw_sync <= sw_p0;
        end
    end

`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_fire;

    // no repeat in the cycle the level is about to drop
    assign rep_fire = r_db && !r_toggle && (rep_cnt == REP_LAST);

    always_ff @(posedge clk0 or negedge rst0) begin
        if (!rst0) begin
            rep_cnt  <= '0;
            en_pulse <= 1'b0;
        end else begin
            if (!r_db || r_toggle || rep_fire) begin
                rep_cnt <= '0;
            end else begin
                rep_cnt <= rep_cnt + REP_W'(1);
            end
            en_pulse <= (r_toggle && !r_db) || rep_fire;
        end
    end
`else
    // registered rising edge, coincident with btn_r_level going high
    always_ff @(posedge clk0 or negedge rst0) begin
        if (!rst0) begin
            en_pulse <= 1'b0;
        end else begin
            en_pulse <= r_toggle && !r_db;
        end
    end
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10.
module tb_btn_conditioner;

    localparam int SEL_RST = 0;
    localparam int SEL_LVL = 1;
    localparam int SEL_SW  = 2;

    typedef struct {
        int          at;
        int          sel;
        logic [15:0] val;
        string       name;
    } chk_t;

    logic        clk0 = 1'b0;
    logic        rst0;
    logic        btn_l_raw;
    logic        btn_r_raw;
    logic [15:0] sw_raw;
    logic        rst_req;
    logic        en_pulse;
    logic [15:0] sw_sync;
    logic        btn_r_level;

    int   cyc = 0;
    int   vectors = 0;
    int   fails = 0;
    int   base;
    chk_t chkq[$];
    int   pulseq[$];

    btn_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .SW_WIDTH        (16),
        .REPEAT_CYCLES   (10)
    ) dut (
        .clk0        (clk0),
        .rst0        (rst0),
        .btn_l_raw   (btn_l_raw),
        .btn_r_raw   (btn_r_raw),
        .sw_raw      (sw_raw),
        .rst_req     (rst_req),
        .en_pulse    (en_pulse),
        .sw_sync     (sw_sync),
        .btn_r_level (btn_r_level)
    );

    always #5 clk0 = ~clk0;

    always @(posedge clk0) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk0);
    endtask

    task automatic chk(input int at, input int sel, input logic [15:0] val, input string name);
        chk_t c;
        int   i;
        c.at   = at;
        c.sel  = sel;
        c.val  = val;
        c.name = name;
        i = chkq.size();
        while (i > 0 && chkq[i-1].at > at) i--;
        chkq.insert(i, c);
    endtask

    task automatic expect_pulse(input int at);
        int i;
        i = pulseq.size();
        while (i > 0 && pulseq[i-1] > at) i--;
        pulseq.insert(i, at);
    endtask

    // monitor: level checkpoints and pulse scoreboard, sampled on the falling edge
    always @(negedge clk0) begin
        chk_t        c;
        logic [15:0] act;
        while (chkq.size() > 0 && chkq[0].at <= cyc) begin
            c = chkq.pop_front();
            case (c.sel)
                SEL_RST: act = {15'b0, rst_req};
                SEL_LVL: act = {15'b0, btn_r_level};
                default: act = sw_sync;
            endcase
            vectors++;
            if (c.at != cyc || act !== c.val) begin
                fails++;
                $display("FAIL %s: cycle %0d got %h, expected %h at cycle %0d",
                         c.name, cyc, act, c.val, c.at);
            end
        end
        if (en_pulse !== 1'b0) begin
            vectors++;
            if (pulseq.size() > 0 && pulseq[0] == cyc) begin
                void'(pulseq.pop_front());
            end else begin
                fails++;
                $display("FAIL en_pulse_unexpected: got en_pulse=%b at cycle %0d, expected 0 (next pulse due %0d)",
                         en_pulse, cyc, (pulseq.size() > 0) ? pulseq[0] : -1);
            end
        end
        while (pulseq.size() > 0 && pulseq[0] < cyc) begin
            vectors++;
            fails++;
            $display("FAIL en_pulse_missing: got no pulse at cycle %0d, expected 1", pulseq[0]);
            void'(pulseq.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst0      = 1'b0;
        btn_l_raw = 1'b1;
        btn_r_raw = 1'b1;
        sw_raw    = 16'hFFFF;

        // reset held with every input high
        tick(2);
        base = cyc;
        chk(base + 1, SEL_RST, 16'd0, "reset_rst_req");
        chk(base + 1, SEL_LVL, 16'd0, "reset_btn_r_level");
        chk(base + 1, SEL_SW,  16'h0000, "reset_sw_sync");
        tick(2);
        rst0 = 1'b1;
        base = cyc;
        chk(base + 1, SEL_SW,  16'h0000, "rel_sw_lat1");
        chk(base + 2, SEL_SW,  16'hFFFF, "rel_sw_lat2");
        chk(base + 5, SEL_RST, 16'd0, "rel_rst_req_early");
        chk(base + 5, SEL_LVL, 16'd0, "rel_btn_r_level_early");
        chk(base + 6, SEL_RST, 16'd1, "rel_rst_req");
        chk(base + 6, SEL_LVL, 16'd1, "rel_btn_r_level");
        expect_pulse(base + 6);
        tick(8);
        btn_l_raw = 1'b0;
        btn_r_raw = 1'b0;
        base = cyc;
        chk(base + 5, SEL_RST, 16'd1, "drop_rst_req_early");
        chk(base + 6, SEL_RST, 16'd0, "drop_rst_req");
        chk(base + 5, SEL_LVL, 16'd1, "drop_level_early");
        chk(base + 6, SEL_LVL, 16'd0, "drop_level");
        tick(10);

        // clean btnR press and release
        btn_r_raw = 1'b1;
        base = cyc;
        chk(base + 5, SEL_LVL, 16'd0, "press_level_early");
        chk(base + 6, SEL_LVL, 16'd1, "press_level");
        chk(base + 8, SEL_RST, 16'd0, "press_rst_req_indep");
        expect_pulse(base + 6);
        tick(8);
        btn_r_raw = 1'b0;
        base = cyc;
        chk(base + 5, SEL_LVL, 16'd1, "release_level_early");
        chk(base + 6, SEL_LVL, 16'd0, "release_level");
        tick(10);

        // bounce 1,0,1,0 for 3 cycles each, then held
        base = cyc;
        chk(base + 6,  SEL_LVL, 16'd0, "bounce_level_a");
        chk(base + 12, SEL_LVL, 16'd0, "bounce_level_b");
        for (int i = 0; i < 4; i++) begin
            btn_r_raw = (i % 2 == 0);
            tick(3);
        end
        btn_r_raw = 1'b1;
        base = cyc;
        chk(base + 5, SEL_LVL, 16'd0, "bounce_final_early");
        chk(base + 6, SEL_LVL, 16'd1, "bounce_final_level");
        expect_pulse(base + 6);
        tick(8);
        btn_r_raw = 1'b0;
        tick(10);

        // switches: 2-cycle latency, no debounce
        sw_raw = 16'hA5C3;
        base = cyc;
        chk(base + 1, SEL_SW, 16'hFFFF, "sw_a_lat1");
        chk(base + 2, SEL_SW, 16'hA5C3, "sw_a_lat2");
        tick(2);
        sw_raw = 16'h5A3C;
        base = cyc;
        chk(base + 1, SEL_SW, 16'hA5C3, "sw_b_lat1");
        chk(base + 2, SEL_SW, 16'h5A3C, "sw_b_lat2");
        tick(4);

        // simultaneous presses
        btn_l_raw = 1'b1;
        btn_r_raw = 1'b1;
        base = cyc;
        chk(base + 5, SEL_RST, 16'd0, "simul_rst_req_early");
        chk(base + 6, SEL_RST, 16'd1, "simul_rst_req");
        chk(base + 6, SEL_LVL, 16'd1, "simul_level");
        expect_pulse(base + 6);
        tick(8);
        btn_l_raw = 1'b0;
        btn_r_raw = 1'b0;
        tick(10);

        // presses again, reset asserted mid-count at cycle 4, released at cycle 6
        btn_l_raw = 1'b1;
        btn_r_raw = 1'b1;
        base = cyc;
        chk(base + 5,  SEL_RST, 16'd0, "midrst_rst_req");
        chk(base + 5,  SEL_SW,  16'h0000, "midrst_sw_sync");
        chk(base + 6,  SEL_LVL, 16'd0, "midrst_level");
        chk(base + 8,  SEL_SW,  16'h5A3C, "midrst_sw_resync");
        chk(base + 11, SEL_RST, 16'd0, "midrst_rst_req_early");
        chk(base + 11, SEL_LVL, 16'd0, "midrst_level_early");
        chk(base + 12, SEL_RST, 16'd1, "midrst_rst_req_after");
        chk(base + 12, SEL_LVL, 16'd1, "midrst_level_after");
        expect_pulse(base + 12);
        tick(4);
        rst0 = 1'b0;
        tick(2);
        rst0 = 1'b1;
        tick(14);
        btn_l_raw = 1'b0;
        btn_r_raw = 1'b0;
        tick(10);

        // btnR held for 40 cycles
        btn_r_raw = 1'b1;
        base = cyc;
        expect_pulse(base + 6);
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
        expect_pulse(base + 16);
        expect_pulse(base + 26);
        expect_pulse(base + 36);
`endif
        chk(base + 20, SEL_LVL, 16'd1, "hold_level_mid");
        chk(base + 40, SEL_LVL, 16'd1, "hold_level_late");
        chk(base + 45, SEL_LVL, 16'd1, "hold_release_early");
        chk(base + 46, SEL_LVL, 16'd0, "hold_release_level");
        tick(40);
        btn_r_raw = 1'b0;
        tick(14);

        while (chkq.size() > 0) begin
            chk_t c;
            c = chkq.pop_front();
            vectors++;
            fails++;
            $display("FAIL %s: got no check by cycle %0d, expected one at cycle %0d", c.name, cyc, c.at);
        end
        while (pulseq.size() > 0) begin
            vectors++;
            fails++;
            $display("FAIL en_pulse_pending: got none by cycle %0d, expected pulse at %0d", cyc, pulseq[0]);
            void'(pulseq.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Input-conditioning stage between the board pins and the processor core. Synchronizes the two push-buttons and the 16 slide switches into the core clock domain, debounces both buttons, and produces a clean reset-request level (`rst_req`, from btnL) and a single-cycle step-enable pulse (`en_pulse`, from btnR). Its outputs drive the processor's `rst0`, `en0` and `sw` inputs directly.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000, consecutive stable cycles required before a debounced button changes state (10 ms at 100 MHz); must be ≥ 1
- `SW_WIDTH`, 16, switch bus width
- `REPEAT_CYCLES`, 25_000_000, auto-repeat interval; used only when `BTN_CONDITIONER_AUTOREPEAT_EN` is defined
- `clk0`  in  1  core clock, 100 MHz; single clock domain
- `rst0`  in  1  asynchronous, active-low reset; async assert, release synchronous to `clk0`
- `btn_l_raw`  in  1  raw btnL pin, asynchronous
- `btn_r_raw`  in  1  raw btnR pin, asynchronous
- `sw_raw`  in  SW_WIDTH  raw switch pins, asynchronous
- `rst_req`  out  1  debounced btnL level, active-high; drives processor `rst0`
- `en_pulse`  out  1  one-cycle pulse per debounced btnR press; drives processor `en0`
- `sw_sync`  out  SW_WIDTH  2-flop-synchronized switches
- `btn_r_level`  out  1  debounced btnR level, for status/debug

## Operation
- Each raw input passes through a 2-flop synchronizer. Switches are synchronized only, not debounced.
- Each button has its own debounce cell. State: debounced level `db`, counter `cnt` of width `$clog2(DEBOUNCE_CYCLES+1)`.
- Per cell FSM: STABLE, CHANGING.
  - STABLE: `cnt`=0. If `sync != db`, go to CHANGING with `cnt`=1.
  - CHANGING: if `sync == db`, return to STABLE and clear `cnt` (glitch rejected). Otherwise increment `cnt`. When `cnt == DEBOUNCE_CYCLES`, toggle `db`, clear `cnt`, and return to STABLE.
- `rst_req` = `db` of the btnL cell.
- `en_pulse` = 1 in the single cycle in which btnR `db` goes 0→1. It is registered and never wider than one cycle. Release (1→0) produces no pulse.
- Both buttons are handled fully independently. Simultaneous presses debounce in parallel, with no priority between them.
- The counter saturates at `DEBOUNCE_CYCLES` and never wraps.

## Timing
- Reset values: `rst_req`=0, `en_pulse`=0, `btn_r_level`=0, `sw_sync`=0. All synchronizer flops, counters and FSMs are cleared (STABLE, `db`=0).
- Sync latency: a raw change appears on the synchronized signal 2 cycles later.
- Debounce latency: a raw button change held stable from cycle 0 updates `db` (and fires `en_pulse` for a btnR press) at cycle 2+DEBOUNCE_CYCLES.
- A bounce of any length shorter than `DEBOUNCE_CYCLES` synchronized cycles causes no output change.
- `sw_sync` latency is exactly 2 cycles.
- Reset asserted mid-count: the count is discarded. After reset release, a button still held requires a full new debounce interval and then produces one `en_pulse`.

## Configuration
- `BTN_CONDITIONER_AUTOREPEAT_EN` defined:
  - While btnR `db` stays 1, a repeat counter issues an additional `en_pulse` every `REPEAT_CYCLES` cycles after the initial pulse.
  - The repeat counter clears on release and on reset.
- Not defined: exactly one pulse per press. No repeat counter is instantiated, and `REPEAT_CYCLES` is ignored.

## Structure
- Shared package `board_pkg`:
  - debounce FSM state enum (STABLE, CHANGING)
  - default constants for `DEBOUNCE_CYCLES` and `REPEAT_CYCLES` at 100 MHz
- Sub-module `debounce_cell`: synchronizer, FSM, counter and `db` output. It is instantiated twice, once per button.
- Edge detection, auto-repeat and the switch synchronizers live in the top module.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `REPEAT_CYCLES`=10.
- Reset: hold `rst0`=0 with all inputs at 1 → all outputs 0. Release `rst0` → `rst_req`=1 at cycle 6, `en_pulse` high only at cycle 6.
- Clean btnR press: 0→1 at cycle 0, held → `en_pulse`=1 at cycle 6 only, `btn_r_level`=1 from cycle 6. Release → no pulse, `btn_r_level`=0 six cycles after release.
- Bounce rejection: btnR toggled 1,0,1,0 with each level held 3 cycles, then held at 1 → no pulse during the bounces. Exactly one pulse 6 cycles after the final rising edge.
- Switches: `sw_raw`=16'hA5C3 at cycle 0 → `sw_sync`=16'hA5C3 at cycle 2, with no debounce delay.
- Simultaneous buttons, plus reset mid-count: btnL and btnR rise on the same cycle → `rst_req` and `en_pulse` both assert at cycle 6. Repeat the presses, then assert `rst0` at cycle 4 → no output change. After release, one pulse follows a full debounce interval.
- With `BTN_CONDITIONER_AUTOREPEAT_EN` defined: hold btnR for 40 cycles → pulses at cycles 6, 16, 26, 36. Without the macro → a single pulse at cycle 6.
